reg_counter_nb: RTL and testbench
=================================

# reg_counter_nb

Parametrised multi-mode register/counter: a WIDTH-bit register with synchronous clear, parallel load, up/down counting (wrap or saturate), and serial shift left/right. Next-generation storage element of the RegCounter lab datapath, replacing fixed 4-bit load-only registers. Also feeds display and timer stages that need terminal-count and overflow indications.

## Interface
- WIDTH, 8, register width in bits (≥2)
- INIT, 0, value taken on reset
- SATURATE, 0, 1 = counting holds at limit instead of wrapping

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous clear to 0
- load  in  1  parallel load of IN
- en  in  1  enable for count/shift operation
- mode  in  2  00 count up, 01 count down, 10 shift left, 11 shift right
- ser_in  in  1  serial input bit for shift modes
- IN  in  WIDTH  parallel load data
- OUT  out  WIDTH  register contents
- tc  out  1  terminal count (combinational)
- ovf  out  1  registered overflow/underflow pulse
- ser_out  out  1  bit shifted out (combinational)

## Operation
- Priority each rising edge: clr > load > en > hold.
- clr: OUT←0, ovf←0.
- load: OUT←IN, ovf←0; mode/en ignored.
- en, mode 00: OUT←OUT+1 modulo 2^WIDTH. At all-ones: wrap to 0 (SATURATE=0) or stay all-ones (SATURATE=1); ovf←1 in both cases.
- en, mode 01: OUT←OUT−1. At 0: wrap to all-ones or stay 0; ovf←1.
- en, mode 10: OUT←{OUT[WIDTH-2:0], ser_in}; ovf←0.
- en, mode 11: OUT←{ser_in, OUT[WIDTH-1:1]}; ovf←0.
- en=0, no clr/load: OUT holds, ovf←0.
- tc = en & ((mode==00 & OUT==all-ones) | (mode==01 & OUT==0)); 0 in shift modes.
- ser_out = OUT[WIDTH-1] in mode 10, OUT[0] in mode 11, 0 otherwise.
- Arithmetic on WIDTH bits; carry is not stored, only reflected in ovf.

## Timing
- Reset: OUT=INIT, ovf=0 immediately on rst_n low, independent of clk; held while low.
- Reset mid-count: state discarded; first operation applied at first rising edge after rst_n high.
- Load/count/shift latency: 1 cycle (visible after the edge).
- ovf: high exactly one cycle after the edge at which the limit was crossed. With continuous counting at the limit and SATURATE=1, ovf stays high every cycle.
- tc: same cycle as OUT reaching the limit, combinational from OUT, mode and en; tc=1 implies ovf=1 on the following cycle unless clr/load intervenes.
- Simultaneous clr+load+en: clr wins, ovf=0.
- Mode change takes effect on the next edge; no internal state besides OUT and ovf.

## Structure
- Shared package reg_counter_pkg: mode encoding constants MODE_UP, MODE_DOWN, MODE_SHL, MODE_SHR (2-bit).
- No sub-module: next-value mux and limit detect live in one always block plus one combinational block.
- Two flops groups only: OUT register, ovf flop.

## Test plan
- WIDTH=4, INIT=5: assert rst_n=0 mid-clock -> OUT=5, ovf=0 without a clock edge; release, en=0 -> OUT stays 5.
- load=1, IN=4'hE, then en=1 mode=00 for 3 cycles -> OUT E,F,0,1; tc=1 while OUT=F; ovf=1 only the cycle OUT=0.
- SATURATE=1, load 4'h1, mode=01 for 3 cycles -> OUT 1,0,0,0; ovf=1 on the 2nd and 3rd post-limit cycles only.
- load 4'b1001, mode=10, ser_in=0,1 -> OUT 0010, 0101; ser_out=1 then 0; mode=11, ser_in=1 -> OUT 1010.
- clr=1, load=1, en=1 together with OUT=7 -> OUT=0, ovf=0; load=1,en=1 with IN=3 -> OUT=3 (no increment).
- Count up continuously 20 cycles from 0 with SATURATE=0 -> OUT equals cycle count mod 16; ovf pulses exactly once per wrap (cycle 16).

Source files
------------

// File: rtl/reg_counter_pkg.sv
// rtl/reg_counter_pkg.sv - mode encodings shared by the register/counter and its users
package reg_counter_pkg;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_SHR  = 2'b11;

endpackage

// File: rtl/reg_counter_nb.sv
// rtl/reg_counter_nb.sv - multi-mode register: clear, load, up/down count (wrap or saturate), serial shift
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset, OUT <= INIT, ovf <= 0
//   clr      synchronous clear (highest priority)
//   load     parallel load of IN (beats en)
//   en       enables the count/shift selected by mode
//   mode     00 up, 01 down, 10 shift left, 11 shift right
//   ser_in   bit entering the register in shift modes
//   IN       parallel load data
//   OUT      register contents
//   tc       terminal count, combinational from OUT, mode, en
//   ovf      one-cycle registered overflow/underflow flag
//   ser_out  bit that the pending shift will push out, combinational
module reg_counter_nb
    import reg_counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INIT     = '0,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    input  logic [WIDTH-1:0] IN,
    output logic [WIDTH-1:0] OUT,
    output logic             tc,
    output logic             ovf,
    output logic             ser_out
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ALL_ZERO = '0;

    logic [WIDTH-1:0] out_q, out_d;
    logic             ovf_q, ovf_d;
    logic             at_max, at_min;

    assign at_max = (out_q == ALL_ONES);
    assign at_min = (out_q == ALL_ZERO);

    always_comb begin
        out_d = out_q;
        ovf_d = 1'b0;
        if (clr) begin
            out_d = ALL_ZERO;
        end else if (load) begin
            out_d = IN;
        end else if (en) begin
            case (mode)
                MODE_UP: begin
                    // The carry is never stored; crossing the top only shows up on ovf.
                    if (at_max) begin
                        ovf_d = 1'b1;
                        out_d = SATURATE ? ALL_ONES : ALL_ZERO;
                    end else begin
                        out_d = out_q + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (at_min) begin
                        ovf_d = 1'b1;
                        out_d = SATURATE ? ALL_ZERO : ALL_ONES;
                    end else begin
                        out_d = out_q - WIDTH'(1);
                    end
                end
                MODE_SHL: out_d = {out_q[WIDTH-2:0], ser_in};
                default:  out_d = {ser_in, out_q[WIDTH-1:1]};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= INIT;
            ovf_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    // tc anticipates the ovf that the next enabled edge will raise.
    assign tc      = en & (((mode == MODE_UP) & at_max) | ((mode == MODE_DOWN) & at_min));
    assign ser_out = (mode == MODE_SHL) ? out_q[WIDTH-1] :
                     (mode == MODE_SHR) ? out_q[0]       : 1'b0;

    assign OUT = out_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_reg_counter_nb.sv
// tb/tb_reg_counter_nb.sv - self-checking bench for reg_counter_nb (wrap and saturate instances)
module tb_reg_counter_nb;

    localparam int W    = 4;
    localparam int MAXV = 15;
    localparam int INITV = 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         ser_in = 1'b0;
    logic [W-1:0] in_v = '0;

    logic [W-1:0] out0, out1;
    logic         tc0, tc1, ovf0, ovf1, so0, so1;

    int checks = 0;
    int errors = 0;

    // reference state: m = register value as plain integer, o = ovf flag
    int m0 = INITV, m1 = INITV;
    int o0 = 0, o1 = 0;

    reg_counter_nb #(.WIDTH(W), .INIT(4'd5), .SATURATE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .en(en), .mode(mode),
        .ser_in(ser_in), .IN(in_v), .OUT(out0), .tc(tc0), .ovf(ovf0), .ser_out(so0)
    );

    reg_counter_nb #(.WIDTH(W), .INIT(4'd5), .SATURATE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .en(en), .mode(mode),
        .ser_in(ser_in), .IN(in_v), .OUT(out1), .tc(tc1), .ovf(ovf1), .ser_out(so1)
    );

    always #5 clk = ~clk;

    task automatic model_step(input int sat, inout int m, inout int o);
        int s;
        s = int'(ser_in);
        if (!rst_n) begin
            m = INITV; o = 0;
        end else if (clr) begin
            m = 0; o = 0;
        end else if (load) begin
            m = int'(in_v); o = 0;
        end else if (en) begin
            case (int'(mode))
                0: if (m == MAXV) begin o = 1; m = sat ? MAXV : 0; end
                   else begin o = 0; m = m + 1; end
                1: if (m == 0) begin o = 1; m = sat ? 0 : MAXV; end
                   else begin o = 0; m = m - 1; end
                2: begin o = 0; m = (m * 2 + s) % 16; end
                default: begin o = 0; m = m / 2 + s * 8; end
            endcase
        end else begin
            o = 0;
        end
    endtask

    task automatic tick();
        model_step(0, m0, o0);
        model_step(1, m1, o1);
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_tc(int m);
        return (en && ((mode == 2'b00 && m == MAXV) || (mode == 2'b01 && m == 0))) ? 1 : 0;
    endfunction

    function automatic int exp_so(int m);
        if (mode == 2'b10) return m / 8;
        if (mode == 2'b11) return m % 2;
        return 0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        load = 1'b1; in_v = 4'hA;
        tick();
        load = 1'b0;
        checks++;
        if (out0 !== 4'hA) begin errors++; $display("FAIL reset_preload out=%0h exp=a", out0); end
        #3;
        rst_n = 1'b0;
        m0 = INITV; m1 = INITV; o0 = 0; o1 = 0;
        #1;
        checks++;
        if (out0 !== 4'd5 || out1 !== 4'd5) begin
            errors++; $display("FAIL reset_async out0=%0h out1=%0h exp=5", out0, out1);
        end
        checks++;
        if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
            errors++; $display("FAIL reset_ovf ovf0=%b ovf1=%b exp=0", ovf0, ovf1);
        end
        en = 1'b1;
        tick();
        checks++;
        if (out0 !== 4'd5) begin errors++; $display("FAIL reset_held out=%0h exp=5", out0); end
        rst_n = 1'b1; en = 1'b0;
        tick();
        checks++;
        if (out0 !== 4'd5 || out1 !== 4'd5) begin
            errors++; $display("FAIL reset_hold_en0 out0=%0h out1=%0h exp=5", out0, out1);
        end
    endtask

    task automatic test_count_wrap();
        logic [3:0] exp_out [3] = '{4'hF, 4'h0, 4'h1};
        logic       exp_tcv [3] = '{1'b1, 1'b0, 1'b0};
        logic       exp_ov  [3] = '{1'b0, 1'b1, 1'b0};
        load = 1'b1; in_v = 4'hE;
        tick();
        load = 1'b0; en = 1'b1; mode = 2'b00;
        #1;
        checks++;
        if (out0 !== 4'hE || tc0 !== 1'b0) begin
            errors++; $display("FAIL wrap_start out=%0h tc=%b exp=e/0", out0, tc0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out0 !== exp_out[i] || tc0 !== exp_tcv[i] || ovf0 !== exp_ov[i]) begin
                errors++;
                $display("FAIL wrap_step%0d out=%0h tc=%b ovf=%b exp=%0h/%b/%b",
                         i, out0, tc0, ovf0, exp_out[i], exp_tcv[i], exp_ov[i]);
            end
        end
        en = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        logic exp_ov [3] = '{1'b0, 1'b1, 1'b1};
        load = 1'b1; in_v = 4'h1;
        tick();
        load = 1'b0; en = 1'b1; mode = 2'b01;
        checks++;
        if (out1 !== 4'h1) begin errors++; $display("FAIL sat_load out=%0h exp=1", out1); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out1 !== 4'h0 || ovf1 !== exp_ov[i] || tc1 !== 1'b1) begin
                errors++;
                $display("FAIL sat_step%0d out=%0h ovf=%b tc=%b exp=0/%b/1", i, out1, ovf1, tc1, exp_ov[i]);
            end
        end
        en = 1'b0;
        tick();
        checks++;
        if (ovf1 !== 1'b0 || out1 !== 4'h0) begin
            errors++; $display("FAIL sat_release ovf=%b out=%0h exp=0/0", ovf1, out1);
        end
    endtask

    task automatic test_shift();
        load = 1'b1; in_v = 4'b1001;
        tick();
        load = 1'b0; en = 1'b1; mode = 2'b10; ser_in = 1'b0;
        #1;
        checks++;
        if (so0 !== 1'b1) begin errors++; $display("FAIL shl_serout0 act=%b exp=1", so0); end
        tick();
        checks++;
        if (out0 !== 4'b0010 || ovf0 !== 1'b0) begin
            errors++; $display("FAIL shl_step0 out=%b ovf=%b exp=0010/0", out0, ovf0);
        end
        ser_in = 1'b1;
        #1;
        checks++;
        if (so0 !== 1'b0) begin errors++; $display("FAIL shl_serout1 act=%b exp=0", so0); end
        tick();
        checks++;
        if (out0 !== 4'b0101) begin errors++; $display("FAIL shl_step1 out=%b exp=0101", out0); end
        mode = 2'b11; ser_in = 1'b1;
        #1;
        checks++;
        if (so0 !== 1'b1 || tc0 !== 1'b0) begin
            errors++; $display("FAIL shr_serout act=%b tc=%b exp=1/0", so0, tc0);
        end
        tick();
        checks++;
        if (out0 !== 4'b1010 || ovf0 !== 1'b0) begin
            errors++; $display("FAIL shr_step out=%b ovf=%b exp=1010/0", out0, ovf0);
        end
        en = 1'b0; ser_in = 1'b0;
    endtask

    task automatic test_priority();
        load = 1'b1; in_v = 4'h7;
        tick();
        clr = 1'b1; load = 1'b1; en = 1'b1; mode = 2'b00; in_v = 4'h9;
        tick();
        checks++;
        if (out0 !== 4'h0 || ovf0 !== 1'b0) begin
            errors++; $display("FAIL prio_clr out=%0h ovf=%b exp=0/0", out0, ovf0);
        end
        clr = 1'b0; in_v = 4'h3;
        tick();
        checks++;
        if (out0 !== 4'h3) begin errors++; $display("FAIL prio_load out=%0h exp=3", out0); end
        in_v = 4'hF;
        tick();
        load = 1'b0; clr = 1'b1;
        tick();
        checks++;
        if (out0 !== 4'h0 || ovf0 !== 1'b0 || out1 !== 4'h0 || ovf1 !== 1'b0) begin
            errors++; $display("FAIL prio_clr_at_limit out=%0h ovf=%b exp=0/0", out0, ovf0);
        end
        clr = 1'b0; en = 1'b0;
    endtask

    task automatic test_long_count();
        int pulses = 0;
        clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b1; mode = 2'b00;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (ovf0 === 1'b1) pulses++;
            checks++;
            if (out0 !== 4'(k % 16) || ovf0 !== (k == 16)) begin
                errors++;
                $display("FAIL long_count k=%0d out=%0h ovf=%b exp=%0h/%0b", k, out0, ovf0, k % 16, k == 16);
            end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL long_pulses act=%0d exp=1", pulses); end
        en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            clr    = ($urandom_range(0, 15) == 0);
            load   = ($urandom_range(0, 7) == 0);
            en     = ($urandom_range(0, 3) != 0);
            mode   = 2'($urandom_range(0, 3));
            ser_in = 1'($urandom_range(0, 1));
            in_v   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            #1;
            checks++;
            if (int'(tc0) != exp_tc(m0) || int'(tc1) != exp_tc(m1) ||
                int'(so0) != exp_so(m0) || int'(so1) != exp_so(m1)) begin
                errors++;
                $display("FAIL rand_comb i=%0d tc=%b/%b so=%b/%b exp=%0d/%0d %0d/%0d",
                         i, tc0, tc1, so0, so1, exp_tc(m0), exp_tc(m1), exp_so(m0), exp_so(m1));
            end
            tick();
            checks++;
            if (int'(out0) != m0 || int'(ovf0) != o0 || int'(out1) != m1 || int'(ovf1) != o1) begin
                errors++;
                $display("FAIL rand_state i=%0d out=%0h/%0h ovf=%b/%b exp=%0h/%0h %0d/%0d",
                         i, out0, out1, ovf0, ovf1, m0, m1, o0, o1);
            end
        end
        clr = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_wrap();
        test_saturate();
        test_shift();
        test_priority();
        test_long_count();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
